// File: rtl/riscv_lsu.sv
// riscv_lsu: RISC-V load/store unit driving a word-addressed, byte-lane memory with an ack handshake
//   request side : clk, reset (sync, active low), req_valid/req_ready, req_we, req_funct3, req_addr, req_wdata
//   response side: resp_valid, resp_err, resp_rdata (sign/zero-extended load result, 0 for stores/errors)
//   memory side  : mem_re, mem_we, mem_addr, mem_be, mem_wdata, mem_rdata, mem_ack
//   trace        : wr, rd, addr, wr_data, rd_data (valid only in the response cycle of a good access)
//   optional     : `define LSU_TIMEOUT_EN to abort an access after TIMEOUT cycles without mem_ack
module riscv_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic                resp_err,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                mem_re,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                wr,
  output logic                rd,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W-1:0]   rd_data
);
  localparam int NB = DATA_W / 8;
  localparam int L = $clog2(NB);
  localparam bit WIDE = DATA_W == 64;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;
  state_t state;
  logic [2:0] f3;
  logic we;
  logic [L-1:0] off;
  logic [1:0] sz;
  logic legal, aligned;
  logic [15:0] be_full;
  logic [NB-1:0] be_req;
  logic [DATA_W-1:0] bmask, wsh, rsh;
  logic [63:0] rsh64, ext64;
  logic [DATA_W-1:0] ext;
  logic unused;
  assign sz = req_funct3[1:0];
  // stores: funct3[2] must be 0, SD only on 64-bit; loads: 011/110 only on 64-bit, 111 never
  assign legal = req_we ? (!req_funct3[2] && (sz != 2'd3 || WIDE))
               : (req_funct3 == 3'b011 || req_funct3 == 3'b110) ? WIDE : req_funct3 != 3'b111;
  assign aligned = (req_addr[2:0] & 3'((4'd1 << sz) - 4'd1)) == 3'd0;
  assign be_full = (16'd1 << (16'd1 << sz)) - 16'd1;
  assign be_req = NB'(be_full) << req_addr[L-1:0];
  always_comb begin
    bmask = '0;
    for (int i = 0; i < NB; i++) bmask[i*8 +: 8] = {8{be_req[i]}};
  end
  assign wsh = (req_wdata << {req_addr[L-1:0], 3'b000}) & bmask;
  assign rsh = mem_rdata >> {off, 3'b000};
  assign rsh64 = 64'(rsh);
  // extension is done at 64 bits so the same expressions serve both data widths
  always_comb begin
    ext64 = f3 == 3'b000 ? {{56{rsh64[7]}}, rsh64[7:0]}
          : f3 == 3'b100 ? {56'd0, rsh64[7:0]}
          : f3 == 3'b001 ? {{48{rsh64[15]}}, rsh64[15:0]}
          : f3 == 3'b101 ? {48'd0, rsh64[15:0]}
          : f3 == 3'b010 ? {{32{rsh64[31]}}, rsh64[31:0]}
          : f3 == 3'b110 ? {32'd0, rsh64[31:0]}
          : rsh64;
  end
  assign ext = DATA_W'(ext64);
  assign unused = ^{req_addr, be_full, ext64};
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      wr         <= 1'b0;
      rd         <= 1'b0;
      addr       <= '0;
      wr_data    <= '0;
      rd_data    <= '0;
      f3         <= '0;
      we         <= 1'b0;
      off        <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          if (legal && aligned) begin
            state     <= ACCESS;
            f3        <= req_funct3;
            we        <= req_we;
            off       <= req_addr[L-1:0];
            mem_re    <= !req_we;
            mem_we    <= req_we;
            mem_addr  <= req_addr[ADDR_W+L-1:L];
            mem_be    <= be_req;
            mem_wdata <= req_we ? wsh : '0;
`ifdef LSU_TIMEOUT_EN
            cnt       <= '0;
`endif
          end else begin
            state      <= ERR;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end
        end
        ACCESS: if (mem_ack) begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= we ? '0 : ext;
          mem_re     <= 1'b0;
          mem_we     <= 1'b0;
          mem_addr   <= '0;
          mem_be     <= '0;
          mem_wdata  <= '0;
          wr         <= we;
          rd         <= !we;
          addr       <= mem_addr;
          wr_data    <= mem_wdata;
          rd_data    <= we ? '0 : ext;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT - 1)) begin
          state      <= ERR;
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          mem_re     <= 1'b0;
          mem_we     <= 1'b0;
          mem_addr   <= '0;
          mem_be     <= '0;
          mem_wdata  <= '0;
          cnt        <= cnt + 1'b1;
        end else cnt <= cnt + 1'b1;
`endif
        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          wr         <= 1'b0;
          rd         <= 1'b0;
          addr       <= '0;
          wr_data    <= '0;
          rd_data    <= '0;
        end
        ERR: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Parametrised load/store unit between the core datapath and the data memory. It accepts one memory request per handshake and decodes RISC-V load/store width from funct3. It drives byte-lane strobes to a word-addressed memory with an ack handshake, sign/zero-extends load results, and flags misaligned or illegal accesses. It also exports the `wr`/`rd`/`addr`/`wr_data`/`rd_data` trace outputs consumed by the top level.

## Interface
- `DATA_W`, 32, data width; legal values 32 or 64.
- `ADDR_W`, 9, memory word-address width.
- `TIMEOUT`, 15, maximum cycles to wait for `mem_ack`; used only with `LSU_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3 of the load/store.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  DATA_W  store data, LSB-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_err`  out  1  qualifies `resp_valid`: misaligned, illegal or timeout.
- `resp_rdata`  out  DATA_W  extended load result; 0 for stores and errors.
- `mem_re` / `mem_we`  out  1  memory read/write strobe.
- `mem_addr`  out  ADDR_W  word address = `req_addr[ADDR_W+L-1:L]`, where L = log2(DATA_W/8).
- `mem_be`  out  DATA_W/8  byte enables.
- `mem_wdata`  out  DATA_W  lane-positioned store data.
- `mem_rdata`  in  DATA_W  read data, valid when `mem_ack` is high.
- `mem_ack`  in  1  memory completion.
- `wr`, `rd`  out  1  trace: completed store/load.
- `addr`  out  ADDR_W  trace word address.
- `wr_data`, `rd_data`  out  DATA_W  trace store data (as on `mem_wdata`) and extended load result.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - ACCESS: strobes held.
  - RESP: `resp_valid`=1.
  - ERR: `resp_valid`=1 and `resp_err`=1.
- IDLE → ACCESS on handshake with a legal, aligned request. Address, funct3, we and data are registered at acceptance.
- IDLE → ERR on handshake with an illegal or misaligned request. No memory strobe is issued.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. When DATA_W=64, also 011 LD and 110 LWU.
  - Stores: 000 SB, 001 SH, 010 SW. When DATA_W=64, also 011 SD.
  - All others are illegal. 011 is illegal at DATA_W=32.
- Alignment: H requires `addr[0]`=0; W requires `addr[1:0]`=0; D requires `addr[2:0]`=0.
- Byte enables: contiguous ones of access size, starting at lane `addr[L-1:0]`.
- Store data is shifted to that lane. Lanes with be=0 are driven 0.
- Loads: the selected lanes are shifted down, then sign-extended (LB/LH/LW) or zero-extended (LBU/LHU/LWU) to DATA_W.
- ACCESS → RESP on `mem_ack`; `mem_rdata` is captured on the ack edge.
- RESP → IDLE and ERR → IDLE unconditionally after one cycle.
- Trace outputs are driven only in the RESP cycle: `wr`=`req_we`, `rd`=!`req_we`, plus `addr` and data. They are 0 otherwise. ERR produces no trace.

## Timing
- Reset values (reset=0 at an edge): state IDLE, `req_ready`=1. All other outputs are 0, including strobes, `resp_*`, `mem_*`, trace outputs and the timeout counter.
- Request accepted at edge N.
- Strobes are high from cycle N+1 until the edge at which `mem_ack`=1 is sampled.
- Earliest ack is cycle N+1. `resp_valid` follows in the cycle after ack, so the minimum load/store latency is 2.
- `req_ready` returns 1 the cycle after RESP. Back-to-back throughput is one request per 3 cycles at zero wait.
- Error path: `resp_valid`/`resp_err` in cycle N+1; ready again at N+2.
- `mem_ack` outside ACCESS is ignored.
- `req_valid` while `req_ready`=0 is not accepted; the requester must hold the request.
- Reset asserted mid-ACCESS: IDLE at the next edge, strobes drop, no response is issued.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When it reaches `TIMEOUT` without an ack, the unit goes to ERR. Strobes drop and `resp_err`=1.
  - A late ack is then ignored.
- `LSU_TIMEOUT_EN` undefined:
  - No counter is instantiated.
  - ACCESS waits indefinitely for `mem_ack`.

## Test plan
- LW, addr 0x8, `mem_rdata`=0xDEADBEEF, ack in the first ACCESS cycle:
  - `mem_addr`=2, `mem_be`=1111.
  - `resp_rdata`=0xDEADBEEF with `resp_valid` 2 cycles after acceptance.
  - `rd`=1, `addr`=2.
- LB vs LBU at addr 0x13, `mem_rdata`=0x80AABBCC:
  - `mem_be`=1000.
  - LB gives `resp_rdata`=0xFFFFFF80; LBU gives 0x00000080.
- SH, addr 0x6, `req_wdata`=0x1234ABCD:
  - `mem_be`=1100, `mem_wdata`=0xABCD0000, `mem_we`=1.
  - `wr`=1, `wr_data`=0xABCD0000.
- Faulty requests raise `resp_err` 1 cycle after acceptance with no strobe and no trace:
  - LW at addr 0x2 (misaligned).
  - funct3=011 with DATA_W=32 (illegal).
- With `LSU_TIMEOUT_EN` and TIMEOUT=15, hold `mem_ack`=0:
  - ERR after 15 ACCESS cycles, strobes drop.
  - A later ack causes no extra `resp_valid`.
- Reset low during ACCESS:
  - All outputs are at reset values the next cycle, `req_ready`=1, no `resp_valid`.
